// File: rtl/spi_ctrl_pkg.sv
// Shared types and widths for the 3-wire SPI master controller.
package spi_ctrl_pkg;

  localparam int SPI_LEN_W  = 5;
  localparam int SPI_DATA_W = 32;
  // Bit counter holds N (1..32), one bit wider than the length field.
  localparam int SPI_CNT_W  = SPI_LEN_W + 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } spi_state_e;

endpackage

// File: rtl/spi_master_ctrl_half_tick.sv
// Free-running SCLK half-period timer: held clear while idle, then pulses
// tick on the last clk cycle of every CLK_DIV-cycle half period.
module spi_half_tick #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt;

  // Count 0..CLK_DIV-1 while running, restart from 0 whenever idle.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      cnt <= '0;
    end else if (!run || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = run && (cnt == LAST);

endmodule

// File: rtl/spi_master_ctrl.sv
// 3-wire SPI master: one transaction per request pulse, IDLE -> SETUP ->
// SHIFT -> HOLD -> GAP. Writes drive all bits; long reads turn SDIO around
// after INSTR_BITS bits and capture the remainder into spi_rdata.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int INSTR_BITS = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  spi_wr_en,
  input  logic                  spi_rd_en,
  input  logic [SPI_LEN_W-1:0]  spi_rw_len,
  input  logic                  spi_d_rise_align,
  input  logic [SPI_DATA_W-1:0] spi_wdata,
  output logic [SPI_DATA_W-1:0] spi_rdata,
  output logic                  spi_busy,
  output logic                  spi_done,
  output logic                  spi_overrun,
  output logic                  spi_csb,
  output logic                  spi_sclk,
  output logic                  spi_sdio_out,
  output logic                  spi_sdio_oe,
  input  logic                  spi_sdio_in
);

  localparam logic [2:0] ST_IDLE  = S_IDLE;
  localparam logic [2:0] ST_SETUP = S_SETUP;
  localparam logic [2:0] ST_SHIFT = S_SHIFT;
  localparam logic [2:0] ST_HOLD  = S_HOLD;
  localparam logic [2:0] ST_GAP   = S_GAP;

  localparam logic [SPI_CNT_W-1:0] INSTR_CNT = SPI_CNT_W'(INSTR_BITS);

  logic [2:0]            state;
  logic                  tick;
  logic [SPI_DATA_W-1:0] tx_sr;
  logic [SPI_DATA_W-1:0] rx_sr;
  logic [SPI_DATA_W-1:0] wdata_msb;
  logic [SPI_CNT_W-1:0]  bit_cnt;
  logic [SPI_CNT_W-1:0]  n_bits;
  logic [SPI_CNT_W-1:0]  req_bits;
  logic                  rd_r;
  logic                  align_r;
  logic                  long_rd;
  logic                  req;
  logic                  sclk_rise;
  logic                  sclk_fall;
  logic                  launch;
  logic                  sample;
  logic                  turn;

  spi_half_tick #(.CLK_DIV(CLK_DIV)) u_half_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (state != ST_IDLE),
    .tick (tick)
  );

  assign req      = spi_wr_en | spi_rd_en;
  assign req_bits = {1'b0, spi_rw_len} + 1'b1;
  // Bit N-1 moved to bit 31 so the shift register always launches from the MSB.
  assign wdata_msb = spi_wdata << (5'd31 - spi_rw_len);

  assign sclk_rise = (state == ST_SHIFT) && tick && !spi_sclk;
  assign sclk_fall = (state == ST_SHIFT) && tick && spi_sclk;
  // With align=0 the first bit is already presented in SETUP, and nothing is
  // launched on the final fall.
  assign launch = align_r ? sclk_rise : (sclk_fall && bit_cnt != '0);
  // Only turned-around bits are captured, so rx_sr ends up right-justified.
  assign sample = (align_r ? sclk_fall : sclk_rise) && !spi_sdio_oe;
  // bit_cnt equals N-k at the launch edge of transmit-order bit k.
  assign turn = long_rd && (bit_cnt == n_bits - INSTR_CNT);

  // Transaction sequencer, shift registers and registered pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      spi_csb      <= 1'b1;
      spi_sclk     <= 1'b0;
      spi_sdio_out <= 1'b0;
      spi_sdio_oe  <= 1'b0;
      spi_busy     <= 1'b0;
      spi_done     <= 1'b0;
      spi_overrun  <= 1'b0;
      spi_rdata    <= '0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      bit_cnt      <= '0;
      n_bits       <= '0;
      rd_r         <= 1'b0;
      align_r      <= 1'b0;
      long_rd      <= 1'b0;
    end else begin
      spi_done    <= 1'b0;
      spi_overrun <= req && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (req) begin
            state       <= ST_SETUP;
            spi_csb     <= 1'b0;
            spi_busy    <= 1'b1;
            spi_sdio_oe <= 1'b1;
            rd_r        <= spi_rd_en;
            align_r     <= spi_d_rise_align;
            long_rd     <= spi_rd_en && ({1'b0, spi_rw_len} >= INSTR_CNT);
            n_bits      <= req_bits;
            bit_cnt     <= req_bits;
            rx_sr       <= '0;
            if (spi_d_rise_align) begin
              spi_sdio_out <= 1'b0;
              tx_sr        <= wdata_msb;
            end else begin
              spi_sdio_out <= wdata_msb[SPI_DATA_W-1];
              tx_sr        <= wdata_msb << 1;
            end
          end
        end
        ST_SETUP: begin
          if (tick) state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (tick) begin
            spi_sclk <= ~spi_sclk;
            if (!spi_sclk) begin
              bit_cnt <= bit_cnt - 1'b1;
            end else if (bit_cnt == '0) begin
              state <= ST_HOLD;
            end
            if (launch) begin
              if (turn || !spi_sdio_oe) begin
                spi_sdio_oe  <= 1'b0;
                spi_sdio_out <= 1'b0;
              end else begin
                spi_sdio_out <= tx_sr[SPI_DATA_W-1];
                tx_sr        <= tx_sr << 1;
              end
            end
            if (sample) rx_sr <= {rx_sr[SPI_DATA_W-2:0], spi_sdio_in};
          end
        end
        ST_HOLD: begin
          if (tick) begin
            state        <= ST_GAP;
            spi_csb      <= 1'b1;
            spi_sdio_oe  <= 1'b0;
            spi_sdio_out <= 1'b0;
            spi_done     <= 1'b1;
            if (rd_r) spi_rdata <= rx_sr;
          end
        end
        ST_GAP: begin
          if (tick) begin
            state    <= ST_IDLE;
            spi_busy <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
